// File: rtl/gl4_box_avg_c.sv
// 2x2 box-averaging pre-filter: each output is the mean of pixels x, x+1 on the
// current and previous line. Define GL4_ROUNDING_EN for round-half-up, else truncate.
module gl4_box_avg_c #(
  parameter int D_WIDTH    = 8,
  parameter int MAX_WIDTH  = 1920,
  parameter int ADDR_WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

`ifdef GL4_ROUNDING_EN
  localparam logic [D_WIDTH+1:0] RND = (D_WIDTH+2)'(2);
`else
  localparam logic [D_WIDTH+1:0] RND = '0;
`endif

  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(MAX_WIDTH - 1);

  // Four D_WIDTH values plus 2 never exceed D_WIDTH+2 bits, so no saturation.
  function automatic logic [D_WIDTH-1:0] avg4(
    input logic [D_WIDTH-1:0] a,
    input logic [D_WIDTH-1:0] b,
    input logic [D_WIDTH-1:0] c,
    input logic [D_WIDTH-1:0] d
  );
    logic [D_WIDTH+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + RND;
    return sum[D_WIDTH+1:2];
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   col_q;
  logic                    first_q;
  logic [D_WIDTH-1:0]      cur_h_q;
  logic [D_WIDTH-1:0]      prev_h_q;
  logic                    tuser_h_q;
  logic [D_WIDTH-1:0]      mem_q [MAX_WIDTH];

  logic                    accept;
  logic                    eff_first;
  logic [D_WIDTH-1:0]      prev_in;

  assign accept    = up_valid & up_ready;
  assign eff_first = up_tuser | first_q;
  // Top line of a frame is replicated upward instead of reading stale memory.
  assign prev_in   = eff_first ? up_data : mem_q[col_q];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    up_ready   = 1'b1;
    down_valid = 1'b0;
    down_data  = '0;
    down_tlast = 1'b0;
    down_tuser = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (up_valid) state_d = up_tlast ? FLUSH : HOLD;
      end
      HOLD: begin
        up_ready   = down_ready;
        down_valid = up_valid;
        down_data  = avg4(cur_h_q, up_data, prev_h_q, prev_in);
        down_tuser = tuser_h_q;
        if (accept) state_d = up_tlast ? FLUSH : HOLD;
      end
      FLUSH: begin
        // Right edge: the held column is replicated horizontally.
        up_ready   = down_ready;
        down_valid = 1'b1;
        down_data  = avg4(cur_h_q, cur_h_q, prev_h_q, prev_h_q);
        down_tlast = 1'b1;
        down_tuser = tuser_h_q;
        if (down_ready) begin
          if (up_valid) state_d = up_tlast ? FLUSH : HOLD;
          else          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      col_q     <= '0;
      first_q   <= 1'b1;
      cur_h_q   <= '0;
      prev_h_q  <= '0;
      tuser_h_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        first_q   <= up_tlast ? 1'b0 : eff_first;
        cur_h_q   <= up_data;
        prev_h_q  <= prev_in;
        tuser_h_q <= eff_first & up_tuser;
        if (up_tlast)             col_q <= '0;
        else if (col_q != COL_LAST) col_q <= col_q + 1'b1;
      end
    end
  end

  // NOTE: the line memory has no reset; the first-line flag masks its contents.
  always_ff @(posedge clk) begin
    if (accept) mem_q[col_q] <= up_data;
  end

endmodule

// File: tb/tb_gl4_box_avg_c.sv
// Directed self-checking bench for gl4_box_avg_c: frames, rounding, backpressure,
// back-to-back lines, 1-pixel lines and mid-line reset.
module tb_gl4_box_avg_c;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] up_data = '0;
  logic       up_valid = 1'b0;
  logic       up_tlast = 1'b0;
  logic       up_tuser = 1'b0;
  logic       up_ready;
  logic [7:0] down_data;
  logic       down_valid;
  logic       down_tlast;
  logic       down_tuser;
  logic       down_ready = 1'b1;

  gl4_box_avg_c #(.D_WIDTH(8), .MAX_WIDTH(1920), .ADDR_WIDTH(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_tlast   (up_tlast),
    .up_tuser   (up_tuser),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_tlast (down_tlast),
    .down_tuser (down_tuser),
    .down_ready (down_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       tlast;
    logic       tuser;
    int         cyc;
  } out_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  out_t outq[$];
  int   stall_cnt = 0;
  int   stall_bad = 0;
  logic prev_stall = 1'b0;
  out_t prev_out;
  bit   bp_en = 0;
  int   bp_phase = 0;

  logic [7:0] l0  [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [7:0] l1  [4] = '{8'd50, 8'd60, 8'd70, 8'd80};
  logic [7:0] ex0 [4] = '{8'd15, 8'd25, 8'd35, 8'd40};
  logic [7:0] ex1 [4] = '{8'd35, 8'd45, 8'd55, 8'd60};

  always @(posedge clk) cyc <= cyc + 1;

  // Ready pattern 1,0,0 repeating when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      down_ready = (bp_phase == 0);
      bp_phase   = (bp_phase + 1) % 3;
    end else begin
      down_ready = 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cnt++;
        if (!down_valid || down_data !== prev_out.data ||
            down_tlast !== prev_out.tlast || down_tuser !== prev_out.tuser)
          stall_bad++;
      end
      if (down_valid && !down_ready && up_ready) stall_bad++;
      prev_stall = down_valid && !down_ready;
      prev_out   = '{down_data, down_tlast, down_tuser, cyc};
      if (down_valid && down_ready) outq.push_back(prev_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1;
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic first);
    int n = 0;
    bit done = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_tlast = last;
    up_tuser = first;
    while (!done) begin
      @(negedge clk);
      if (up_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout pixel %0d never accepted, want accept within 100 cycles", d);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < 8; i++) begin
      send(i < 4 ? l0[i] : l1[i-4], (i % 4) == 3, i == 0);
      if (gap) idle(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (down_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", down_valid); end
    n_cmp++; if (down_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %b want 0", down_tlast); end
    n_cmp++; if (down_tuser !== 1'b0) begin n_bad++; $display("FAIL reset_tuser got %b want 0", down_tuser); end
    n_cmp++; if (down_data !== 8'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", down_data); end
    n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", up_ready); end
  endtask

  task automatic test_frame();
    do_reset();
    send_frame(1'b1);
    idle(4);
    n_cmp++;
    if (outq.size() != 8) begin n_bad++; $display("FAIL frame_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      logic [7:0] ed;
      ed = (i < 4) ? ex0[i] : ex1[i-4];
      n_cmp++;
      if (outq[i].data !== ed || outq[i].tlast !== ((i % 4) == 3) || outq[i].tuser !== (i == 0)) begin
        n_bad++;
        $display("FAIL frame_out[%0d] got d=%0d l=%b u=%b want d=%0d l=%b u=%b", i,
                 outq[i].data, outq[i].tlast, outq[i].tuser, ed, (i % 4) == 3, i == 0);
      end
    end
  endtask

  task automatic test_rounding();
    logic [7:0] ed [2];
`ifdef GL4_ROUNDING_EN
    ed = '{8'd2, 8'd2};
`else
    ed = '{8'd1, 8'd2};
`endif
    do_reset();
    send(8'd1, 1'b0, 1'b1);
    send(8'd2, 1'b1, 1'b0);
    idle(3);
    n_cmp++;
    if (outq.size() != 2) begin n_bad++; $display("FAIL round_count got %0d want 2", outq.size()); end
    for (int i = 0; i < 2 && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i].data !== ed[i] || outq[i].tlast !== (i == 1) || outq[i].tuser !== (i == 0)) begin
        n_bad++;
        $display("FAIL round_out[%0d] got d=%0d l=%b u=%b want d=%0d l=%b u=%b", i,
                 outq[i].data, outq[i].tlast, outq[i].tuser, ed[i], i == 1, i == 0);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    stall_cnt = 0;
    stall_bad = 0;
    bp_phase  = 0;
    bp_en     = 1;
    send_frame(1'b0);
    idle(12);
    bp_en = 0;
    idle(2);
    n_cmp++;
    if (outq.size() != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      logic [7:0] ed;
      ed = (i < 4) ? ex0[i] : ex1[i-4];
      n_cmp++;
      if (outq[i].data !== ed || outq[i].tlast !== ((i % 4) == 3) || outq[i].tuser !== (i == 0)) begin
        n_bad++;
        $display("FAIL bp_out[%0d] got d=%0d l=%b u=%b want d=%0d l=%b u=%b", i,
                 outq[i].data, outq[i].tlast, outq[i].tuser, ed, (i % 4) == 3, i == 0);
      end
    end
    n_cmp++;
    if (stall_cnt == 0) begin n_bad++; $display("FAIL bp_stalls got %0d stalled cycles want >0", stall_cnt); end
    n_cmp++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable/ready stall cycles want 0", stall_bad); end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = cyc;
    send_frame(1'b0);
    idle(4);
    n_cmp++;
    if (outq.size() != 8) begin n_bad++; $display("FAIL b2b_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      logic [7:0] ed;
      ed = (i < 4) ? ex0[i] : ex1[i-4];
      n_cmp++;
      if (outq[i].data !== ed || outq[i].cyc != start + 1 + i) begin
        n_bad++;
        $display("FAIL b2b_out[%0d] got d=%0d cyc=%0d want d=%0d cyc=%0d", i,
                 outq[i].data, outq[i].cyc - start, ed, 1 + i);
      end
    end
  endtask

  task automatic test_one_pixel();
    do_reset();
    send(8'd7, 1'b1, 1'b1);
    send(8'd9, 1'b1, 1'b0);
    idle(3);
    n_cmp++;
    if (outq.size() != 2) begin n_bad++; $display("FAIL one_count got %0d want 2", outq.size()); end
    if (outq.size() >= 2) begin
      n_cmp++;
      if (outq[0].data !== 8'd7 || outq[0].tlast !== 1'b1 || outq[0].tuser !== 1'b1) begin
        n_bad++;
        $display("FAIL one_out0 got d=%0d l=%b u=%b want d=7 l=1 u=1",
                 outq[0].data, outq[0].tlast, outq[0].tuser);
      end
      n_cmp++;
      if (outq[1].data !== 8'd8 || outq[1].tlast !== 1'b1 || outq[1].tuser !== 1'b0) begin
        n_bad++;
        $display("FAIL one_out1 got d=%0d l=%b u=%b want d=8 l=1 u=0",
                 outq[1].data, outq[1].tlast, outq[1].tuser);
      end
    end
  endtask

  task automatic test_midline_reset();
    do_reset();
    for (int i = 0; i < 4; i++) send(l0[i], i == 3, i == 0);
    send(l1[0], 1'b0, 1'b0);
    send(l1[1], 1'b0, 1'b0);
    rst = 1'b1;
    up_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (down_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b want 0", down_valid); end
    n_cmp++; if (up_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_ready got %b want 1", up_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
    for (int i = 0; i < 4; i++) send(l0[i], i == 3, i == 0);
    idle(3);
    n_cmp++;
    if (outq.size() != 4) begin n_bad++; $display("FAIL mrst_count got %0d want 4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      n_cmp++;
      if (outq[i].data !== ex0[i] || outq[i].tlast !== (i == 3) || outq[i].tuser !== (i == 0)) begin
        n_bad++;
        $display("FAIL mrst_out[%0d] got d=%0d l=%b u=%b want d=%0d l=%b u=%b", i,
                 outq[i].data, outq[i].tlast, outq[i].tuser, ex0[i], i == 3, i == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_one_pixel();
    test_midline_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gl4_box_avg_c.md
Name: gl4_box_avg_c

Overview:
2x2 box-averaging pre-filter that sits directly upstream of the 2x2 decimation stage in the video downscaler.
- Each output pixel is the rounded mean of a 2x2 input neighbourhood: current line pixels x and x+1, and previous line pixels x and x+1.
- The decimator's kept pixels (even column, odd line) therefore carry a proper box-filtered value instead of a point sample.
- Pixel count, tlast and tuser are preserved one-for-one, so the downstream decimation counters are unaffected.

Parameters:
D_WIDTH, 8, pixel data width
MAX_WIDTH, 1920, maximum pixels per line (line-memory depth)
ADDR_WIDTH, 11, column counter / line-memory address width; must satisfy 2^ADDR_WIDTH >= MAX_WIDTH

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
up_data  input  D_WIDTH  input pixel
up_valid  input  1  input pixel valid
up_tlast  input  1  last pixel of line
up_tuser  input  1  first pixel of frame
up_ready  output  1  block accepts input this cycle
down_data  output  D_WIDTH  averaged pixel
down_valid  output  1  output valid
down_tlast  output  1  last pixel of line
down_tuser  output  1  first pixel of frame
down_ready  input  1  downstream accepts

Behaviour:
Interface and handshake
- One clock (clk); reset rst is synchronous and active-high.
- Transfer on either side = valid & ready in the same cycle. up_ready never depends on up_valid.

Line memory
- MAX_WIDTH x D_WIDTH array, asynchronous read, read-before-write at address col.
- On every input accept: mem[col] <= up_data.
- col increments on each accept and returns to 0 on an accept with up_tlast.
- If col reaches MAX_WIDTH-1 without tlast, col holds (clamps); output values beyond that column are don't-care.

First-line handling
- first_reg resets to 1.
- eff_first = up_tuser | first_reg.
- On accept: first_reg <= up_tlast ? 0 : eff_first.
- prev_in = eff_first ? up_data : mem[col], i.e. the top line is replicated upward.

Hold register
- Fields: cur_h, prev_h, tuser_h.
- Loaded on every accept with up_data, prev_in and eff_first&up_tuser.

Arithmetic
- sum = a+b+c+d in D_WIDTH+2 bits; out = (sum + R) >> 2, giving D_WIDTH bits with no saturation needed.
- R = 2 or 0; see Optional Feature.

FSM (state reset value EMPTY)
- EMPTY:
  - down_valid=0, up_ready=1.
  - On accept: go to FLUSH if up_tlast, else HOLD.
- HOLD (pixel x held, waiting for x+1):
  - down_valid = up_valid; up_ready = down_ready.
  - down_data = avg(cur_h, up_data, prev_h, prev_in); down_tlast=0; down_tuser=tuser_h.
  - On transfer: reload hold; go to FLUSH if up_tlast, else stay in HOLD.
- FLUSH (held pixel is the last of its line):
  - down_valid=1; down_data = avg(cur_h, cur_h, prev_h, prev_h) (right edge replicated); down_tlast=1; down_tuser=tuser_h.
  - up_ready = down_ready; a new pixel may be accepted in the same cycle as the flush transfer.
  - On down transfer: with a simultaneous accept, reload and go to HOLD/FLUSH per up_tlast; otherwise go to EMPTY.
  - down_ready=0 stalls both sides.

Timing, reset and boundary cases
- Latency: output x is presented in the cycle input x+1 is presented. The end-of-line output follows one cycle after the tlast accept.
- Throughput: 1 pixel/cycle sustained, including across line boundaries.
- Reset values: down_valid=0, down_tlast=0, down_tuser=0, down_data=0, up_ready=1. col=0, state=EMPTY, first_reg=1.
- rst mid-line discards the held pixel. The line memory is not cleared; the next line is treated as first.
- A 1-pixel line (tuser/tlast on the same pixel) goes EMPTY -> FLUSH, giving out = avg(p,p,p,p) = p.
- up_tuser mid-line forces vertical replication for the remainder of that line and resyncs the next line.

Optional Feature:
GL4_ROUNDING_EN
- Defined: R=2, round-half-up.
- Undefined: R=0, truncation; all other behaviour is identical.

Test Plan:
1. Width-4 frame, always ready. Line0 10,20,30,40 (tuser on 10). Line1 50,60,70,80. -> out line0 15,25,35,40 (tuser on first, tlast on 40); line1 35,45,55,60 (tlast on 60).
2. Rounding: line0 1,2 tuser. -> out 2,2 with GL4_ROUNDING_EN; 1,2 without.
3. Backpressure: case 1 with down_ready toggled 1,0,0,1... -> same output sequence. down_data/tlast/tuser held stable while valid & !ready; up_ready=0 during stalls.
4. Back-to-back lines, up_valid=1 every cycle. -> no bubble: FLUSH transfer and next-line accept in the same cycle, 8 outputs in 9 cycles.
5. 1-pixel lines 7 (tuser+tlast) then 9 (tlast). -> out 7 tlast=1 tuser=1, then (7+7+9+9+2)>>2=8 tlast=1.
6. rst asserted after 2 pixels of line1 in case 1, then a new frame. -> next cycle down_valid=0, up_ready=1; new frame output equals case 1 line0.
